// File: rtl/sisr_signature_checker.sv
// -----------------------------------------------------------------------------
// sisr_signature_checker
//
// Serial-input signature register with session control. Sits downstream of the
// serial random sequence generator and the circuit under test. It compacts the
// serial response stream into an N-bit signature, counts the accepted bits,
// compares the final signature against a golden value and reports done/pass.
//
// The compaction uses the same internal-XOR (Galois) convention as the
// generator, so with sin held at 0 the update equals the generator's
// next-state function.
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | no session; waiting for start
//   S_LOAD  | one cycle: signature <= seed, counter <= 0, num_bits latched
//   S_RUN   | generator enabled; each sin_valid cycle compacts one bit
//   S_CHECK | one cycle: pass <= (signature == golden)
//   S_DONE  | result held; start begins a new session
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   session request (honoured in IDLE/DONE only)
//   abort      in   cancel; FSM returns to IDLE, beats start
//   poly       in   [N]     feedback taps (poly[N-1] ignored)
//   seed       in   [N]     initial signature
//   golden     in   [N]     expected final signature
//   num_bits   in   [CNT_W] bits to compact, sampled in LOAD
//   sin        in   serial response bit
//   sin_valid  in   sin is compacted this cycle (RUN only)
//   gen_en     out  upstream generator enable, 1 exactly in RUN
//   busy       out  1 in LOAD, RUN, CHECK
//   done       out  1 in DONE
//   pass       out  registered compare result
//   signature  out  [N]     signature register
// -----------------------------------------------------------------------------
module sisr_signature_checker #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N-1:0]     poly,
    input  logic [N-1:0]     seed,
    input  logic [N-1:0]     golden,
    input  logic [CNT_W-1:0] num_bits,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             gen_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N-1:0]     signature
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_bits_q, num_bits_d;
    logic             pass_q, pass_d;

    logic             fb;
    logic [N-1:0]     poly_eff;
    logic [N-1:0]     sig_upd;
    logic [CNT_W-1:0] cnt_inc;

    // SISR next value. The MSB tap is forced to 1 so bit N-1 always takes the
    // feedback, whatever the caller puts in poly[N-1].
    always_comb begin
        fb       = sig_q[0] ^ sin;
        poly_eff = poly | {1'b1, {(N-1){1'b0}}};
        sig_upd  = {1'b0, sig_q[N-1:1]} ^ ({N{fb}} & poly_eff);
    end

    // Counter never wraps in practice: RUN exits on exact equality with the
    // latched length, so the full CNT_W range of num_bits is usable.
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        sig_d      = sig_q;
        cnt_d      = cnt_q;
        num_bits_d = num_bits_q;
        pass_d     = pass_q;

        case (state_q)
            S_IDLE: begin
                if (abort) begin
                    pass_d  = 1'b0;
                end else if (start) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (abort) begin
                    // Abort wins over the load; the signature keeps its old value.
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    sig_d      = seed;
                    cnt_d      = '0;
                    num_bits_d = num_bits;
                    pass_d     = 1'b0;
                    // A zero-length session skips RUN; the result is the seed.
                    state_d    = (num_bits == '0) ? S_CHECK : S_RUN;
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else if (sin_valid) begin
                    sig_d = sig_upd;
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_bits_q) begin
                        state_d = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    pass_d  = (sig_q == golden);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else if (start) begin
                    state_d = S_LOAD;
                end
            end

            default: begin
                state_d = S_IDLE;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sig_q      <= '0;
            cnt_q      <= '0;
            num_bits_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sig_q      <= sig_d;
            cnt_q      <= cnt_d;
            num_bits_q <= num_bits_d;
            pass_q     <= pass_d;
        end
    end

    assign gen_en    = (state_q == S_RUN);
    assign busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_sisr_signature_checker.sv
module tb_sisr_signature_checker;
    localparam int N  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort, sin, sin_valid;
    logic [N-1:0]  poly, seed, golden;
    logic [CW-1:0] num_bits;
    logic          gen_en, busy, done, pass;
    logic [N-1:0]  signature;

    sisr_signature_checker #(.N(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .poly(poly), .seed(seed), .golden(golden), .num_bits(num_bits),
        .sin(sin), .sin_valid(sin_valid),
        .gen_en(gen_en), .busy(busy), .done(done), .pass(pass),
        .signature(signature)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] sig;
        logic         pass;
    } exp_t;
    exp_t         exp_q[$];
    exp_t         e;
    logic [N-1:0] model_sig;

    // Reference Galois step, written as shift-then-conditional-XOR.
    function automatic logic [N-1:0] ref_step(input logic [N-1:0] s, input logic b,
                                              input logic [N-1:0] p);
        logic         f;
        logic [N-1:0] r;
        f = s[0] ^ b;
        r = {f, s[N-1:1]};
        if (f) r = r ^ {1'b0, p[N-2:0]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; on return the DUT is in LOAD.
    task automatic begin_session(input logic [N-1:0] s, input logic [N-1:0] g,
                                 input logic [CW-1:0] nb);
        seed      = s;
        golden    = g;
        num_bits  = nb;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        model_sig = s;
    endtask

    task automatic feed(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        sin       = 1'b0;
        model_sig = ref_step(model_sig, b, poly);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        poly = 8'h1D; seed = '0; golden = '0; num_bits = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({gen_en, busy, done, pass} !== 4'b0000 || signature !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got gen_en/busy/done/pass=%b%b%b%b sig=%h want 0000 sig=00",
                     gen_en, busy, done, pass, signature);
        end
    endtask

    task automatic test_single_bit();
        poly = 8'h1D;
        begin_session(8'h00, 8'h9D, 1);
        total++;
        if (gen_en !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL t1_load got gen_en=%b busy=%b want 0 1", gen_en, busy);
        end
        tick();
        total++;
        if (gen_en !== 1'b1 || signature !== 8'h00) begin
            bad++; $display("FAIL t1_run got gen_en=%b sig=%h want 1 00", gen_en, signature);
        end
        feed(1'b1);
        exp_q.push_back('{model_sig, model_sig == golden});
        total++;
        if (gen_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || signature !== 8'h9D) begin
            bad++; $display("FAIL t1_check got gen_en=%b busy=%b done=%b sig=%h want 0 1 0 9d",
                            gen_en, busy, done, signature);
        end
        tick();
        e = exp_q.pop_front();
        total++;
        if (done !== 1'b1 || gen_en !== 1'b0) begin
            bad++; $display("FAIL t1_done_latency got done=%b gen_en=%b want 1 0", done, gen_en);
        end
        total++;
        if (signature !== e.sig || pass !== e.pass || pass !== 1'b1) begin
            bad++; $display("FAIL t1_result got sig=%h pass=%b want sig=%h pass=1", signature, pass, e.sig);
        end
    endtask

    task automatic test_gaps();
        bit ok;
        for (int k = 0; k < 2; k++) begin
            // Second pass starts straight from DONE with a wrong golden value.
            begin_session(8'h00, (k == 0) ? 8'hD3 : 8'hD2, 2);
            tick();
            feed(1'b1);
            for (int g = 0; g < 3; g++) begin
                tick();
                total++;
                if (signature !== 8'h9D || gen_en !== 1'b1) begin
                    bad++; $display("FAIL t2_gap_hold got sig=%h gen_en=%b want 9d 1", signature, gen_en);
                end
            end
            feed(1'b0);
            exp_q.push_back('{model_sig, model_sig == golden});
            wait_done(4, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL t2_done_timeout got done=0 want 1");
                void'(exp_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                total++;
                if (signature !== e.sig || signature !== 8'hD3 || pass !== e.pass) begin
                    bad++; $display("FAIL t2_result got sig=%h pass=%b want sig=%h pass=%b",
                                    signature, pass, e.sig, e.pass);
                end
            end
        end
    endtask

    task automatic test_zero_bits();
        bit saw_gen = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        begin_session(8'hA5, 8'hA5, 0);
        exp_q.push_back('{8'hA5, 1'b1});
        saw_gen |= gen_en;
        tick();
        saw_gen |= gen_en;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL t3_check got busy=%b done=%b want 1 0", busy, done);
        end
        tick();
        saw_gen |= gen_en;
        e = exp_q.pop_front();
        total++;
        if (done !== 1'b1 || signature !== e.sig || pass !== e.pass) begin
            bad++; $display("FAIL t3_result got done=%b sig=%h pass=%b want 1 %h %b",
                            done, signature, pass, e.sig, e.pass);
        end
        total++;
        if (saw_gen !== 1'b0) begin
            bad++; $display("FAIL t3_gen_en got asserted want never");
        end
    endtask

    task automatic test_abort();
        bit ok;
        logic [N-1:0] mid;
        begin_session(8'h3C, 8'h00, 100);
        tick();
        for (int i = 0; i < 40; i++) feed(1'($urandom_range(0, 1)));
        mid   = model_sig;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({gen_en, busy, done, pass} !== 4'b0000 || signature !== mid) begin
            bad++; $display("FAIL t4_abort got gen_en/busy/done/pass=%b%b%b%b sig=%h want 0000 sig=%h",
                            gen_en, busy, done, pass, signature, mid);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL t4_stay_idle got busy=%b want 0", busy);
        end
        begin_session(8'h3C, 8'h00, 100);
        tick();
        total++;
        if (signature !== 8'h3C) begin
            bad++; $display("FAIL t4_reseed got sig=%h want 3c", signature);
        end
        for (int i = 0; i < 100; i++) feed(1'($urandom_range(0, 1)));
        golden = model_sig;
        exp_q.push_back('{model_sig, 1'b1});
        wait_done(4, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL t4_done_timeout got done=0 want 1");
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            total++;
            if (signature !== e.sig || pass !== e.pass) begin
                bad++; $display("FAIL t4_rerun got sig=%h pass=%b want %h %b", signature, pass, e.sig, e.pass);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] b;
        begin_session(8'h5A, 8'h00, 10);
        tick();
        feed(1'b1);
        feed(1'b0);
        rst = 1'b1; sin_valid = 1'b1; sin = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; sin_valid = 1'b0; sin = 1'b0; start = 1'b0;
        total++;
        if ({gen_en, busy, done, pass} !== 4'b0000 || signature !== 8'h00) begin
            bad++; $display("FAIL t5_rst got gen_en/busy/done/pass=%b%b%b%b sig=%h want 0000 sig=00",
                            gen_en, busy, done, pass, signature);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL t5_rst_start_ignored got busy=%b want 0", busy);
        end
        b = 8'($urandom);
        begin_session(8'hC3, 8'h00, 3);
        tick();
        feed(b[0]);
        start = 1'b1; tick(); start = 1'b0;
        total++;
        if (gen_en !== 1'b1 || signature !== model_sig) begin
            bad++; $display("FAIL t5_start_busy got gen_en=%b sig=%h want 1 %h", gen_en, signature, model_sig);
        end
        feed(b[1]);
        total++;
        if (gen_en !== 1'b1) begin
            bad++; $display("FAIL t5_count got gen_en=%b after 2 bits want 1", gen_en);
        end
        feed(b[2]);
        exp_q.push_back('{model_sig, model_sig == golden});
        tick();
        e = exp_q.pop_front();
        total++;
        if (done !== 1'b1 || signature !== e.sig || pass !== e.pass) begin
            bad++; $display("FAIL t5_result got done=%b sig=%h pass=%b want 1 %h %b",
                            done, signature, pass, e.sig, e.pass);
        end
    endtask

    task automatic test_long_random();
        int  accepted = 0;
        int  cycles   = 0;
        bit  v, ok;
        logic bit_v;
        logic [N-1:0] s2;
        poly = 8'h1D;
        begin_session(8'($urandom), 8'($urandom), 1000);
        tick();
        while (accepted < 1000 && cycles < 5000) begin
            v     = ($urandom_range(0, 3) != 0);
            bit_v = 1'($urandom_range(0, 1));
            sin = bit_v; sin_valid = v;
            tick();
            sin_valid = 1'b0;
            cycles++;
            if (v) begin
                model_sig = ref_step(model_sig, bit_v, poly);
                accepted++;
            end
            total++;
            if (signature !== model_sig) begin
                bad++; $display("FAIL t6_cycle%0d got sig=%h want %h", cycles, signature, model_sig);
            end
        end
        exp_q.push_back('{model_sig, model_sig == golden});
        wait_done(4, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL t6_done_timeout got done=0 want 1");
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            total++;
            if (signature !== e.sig || pass !== e.pass) begin
                bad++; $display("FAIL t6_result got sig=%h pass=%b want %h %b", signature, pass, e.sig, e.pass);
            end
        end
        s2 = 8'h81;
        begin_session(s2, 8'h00, 5);
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || gen_en !== 1'b0) begin
            bad++; $display("FAIL t6_b2b_load got busy=%b done=%b gen_en=%b want 1 0 0", busy, done, gen_en);
        end
        tick();
        total++;
        if (gen_en !== 1'b1 || signature !== s2) begin
            bad++; $display("FAIL t6_b2b_run got gen_en=%b sig=%h want 1 %h", gen_en, signature, s2);
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_gaps();
        test_zero_bits();
        test_abort();
        test_reset_mid();
        test_long_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
